// File: rtl/gun_position_gen.sv
// Crosshair position generator for the williams2 gun ADC path.
// Digital mode integrates joystick presses into a saturating position that
// speeds up while a direction is held. Analog mode tracks a stick instead.
// Everything advances on rising edges of the core's 4 ms tick.
module gun_position_gen #(
  parameter int unsigned WIDTH       = 6,
  parameter int unsigned MAX         = 63,
  parameter int unsigned CENTER      = 32,
  parameter int unsigned SLOW_DIV    = 4,
  parameter int unsigned ACCEL_TICKS = 16,
  parameter int unsigned FAST_STEP   = 2,
  parameter bit          INVERT_V    = 1'b0
) (
  input  logic             clock_12,
  input  logic             reset,
  input  logic             tick_4ms,
  input  logic             joy_left,
  input  logic             joy_right,
  input  logic             joy_up,
  input  logic             joy_down,
  input  logic             recenter,
  input  logic             analog_en,
  input  logic [7:0]       analog_x,
  input  logic [7:0]       analog_y,
  output logic [WIDTH-1:0] gun_h,
  output logic [WIDTH-1:0] gun_v,
  output logic             moving
);

  localparam int unsigned DivW  = (SLOW_DIV > 1) ? $clog2(SLOW_DIV) : 1;
  localparam int unsigned HoldW = $clog2(ACCEL_TICKS + 1);
  localparam int unsigned Shift = 8 - WIDTH;
  // Two guard bits keep the signed sum clear of overflow before clamping.
  localparam int unsigned SumW  = WIDTH + 2;

  localparam logic signed [SumW-1:0] MaxS = SumW'(MAX);

  typedef enum logic [1:0] {StIdle, StSlow, StFast} axis_state_e;

  typedef struct packed {
    axis_state_e      state;
    logic             dir_neg;   // latched direction: 1 = moving toward 0
    logic [DivW-1:0]  div_cnt;
    logic [HoldW-1:0] hold_cnt;
    logic [WIDTH-1:0] pos;
  } axis_t;

  axis_t h_q, h_d;
  axis_t v_q, v_d;
  logic  tick_d;
  logic  moving_q;
  logic  step;
  logic  h_valid, h_neg;
  logic  v_valid, v_neg;

  // Add or subtract amt and saturate into [0, MAX]; never wraps.
  function automatic logic [WIDTH-1:0] clamp_move(logic [WIDTH-1:0] pos, logic neg,
                                                  int unsigned amt);
    logic signed [SumW-1:0] base;
    logic signed [SumW-1:0] delta;
    logic signed [SumW-1:0] sum;
    base  = $signed({2'b00, pos});
    delta = $signed(SumW'(amt));
    if (neg) begin
      delta = -delta;
    end
    sum = base + delta;
    if (sum[SumW-1]) begin
      return '0;
    end else if (sum > MaxS) begin
      return WIDTH'(MAX);
    end
    return sum[WIDTH-1:0];
  endfunction

  // Axis parked in IDLE with cleared counters at the given position.
  function automatic axis_t idle_at(logic [WIDTH-1:0] pos);
    axis_t n;
    n.state    = StIdle;
    n.dir_neg  = 1'b0;
    n.div_cnt  = '0;
    n.hold_cnt = '0;
    n.pos      = pos;
    return n;
  endfunction

  // One step event under the SLOW rule; the step that completes the hold
  // count still moves by the slow rule, then the axis goes FAST.
  function automatic axis_t slow_step(axis_t a);
    axis_t n;
    n = a;
    if (a.div_cnt == '0) begin
      n.pos = clamp_move(a.pos, a.dir_neg, 1);
    end
    if (a.div_cnt == DivW'(SLOW_DIV - 1)) begin
      n.div_cnt = '0;
    end else begin
      n.div_cnt = a.div_cnt + 1'b1;
    end
    n.hold_cnt = a.hold_cnt + 1'b1;
    if (n.hold_cnt == HoldW'(ACCEL_TICKS)) begin
      n.state = StFast;
    end
    return n;
  endfunction

  // Digital-mode next state for one axis.
  function automatic axis_t axis_next(axis_t cur, logic valid, logic neg, logic stp);
    axis_t n;
    n = cur;
    if (!valid) begin
      n = idle_at(cur.pos);
    end else if (cur.state == StIdle || cur.dir_neg != neg) begin
      // Fresh press or reversal restarts the slow phase. Only a fresh press
      // may move in the same cycle; a reversal waits for the next step.
      n.state    = StSlow;
      n.dir_neg  = neg;
      n.div_cnt  = '0;
      n.hold_cnt = '0;
      if (cur.state == StIdle && stp) begin
        n = slow_step(n);
      end
    end else if (stp) begin
      if (cur.state == StFast) begin
        n.pos = clamp_move(cur.pos, cur.dir_neg, FAST_STEP);
      end else begin
        n = slow_step(cur);
      end
    end
    return n;
  endfunction

  // Offset-binary stick value scaled to WIDTH bits and clamped to MAX.
  function automatic logic [WIDTH-1:0] analog_pos(logic [7:0] raw);
    logic [7:0] biased;
    biased = (raw ^ 8'h80) >> Shift;
    if (biased > 8'(MAX)) begin
      return WIDTH'(MAX);
    end
    return WIDTH'(biased);
  endfunction

  // Step detect and joystick direction decode; opposing pairs cancel.
  always_comb begin
    step    = tick_4ms & ~tick_d;
    h_valid = joy_left ^ joy_right;
    h_neg   = joy_left;
    v_valid = joy_up ^ joy_down;
    v_neg   = INVERT_V ? joy_down : joy_up;
  end

  // Next axis state: recenter beats analog, analog beats digital movement.
  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (recenter) begin
      h_d = idle_at(WIDTH'(CENTER));
      v_d = idle_at(WIDTH'(CENTER));
    end else if (analog_en) begin
      h_d = idle_at(step ? analog_pos(analog_x) : h_q.pos);
      v_d = idle_at(step ? analog_pos(INVERT_V ? ~analog_y : analog_y) : v_q.pos);
    end else begin
      h_d = axis_next(h_q, h_valid, h_neg, step);
      v_d = axis_next(v_q, v_valid, v_neg, step);
    end
  end

  // Register both axes, the tick history and the moving flag.
  always_ff @(posedge clock_12 or posedge reset) begin
    if (reset) begin
      h_q      <= idle_at(WIDTH'(CENTER));
      v_q      <= idle_at(WIDTH'(CENTER));
      tick_d   <= 1'b0;
      moving_q <= 1'b0;
    end else begin
      h_q      <= h_d;
      v_q      <= v_d;
      tick_d   <= tick_4ms;
      moving_q <= (h_d.state != StIdle) | (v_d.state != StIdle);
    end
  end

  assign gun_h  = h_q.pos;
  assign gun_v  = v_q.pos;
  assign moving = moving_q;

endmodule

// File: tb/tb_gun_position_gen.sv
// Bench for gun_position_gen: directed walk through the key scenarios with
// literal expectations, then randomized stimulus against a behavioural model.
module tb_gun_position_gen;

  localparam int MaxV = 63;
  localparam int Cen  = 32;
  localparam int ModeIdle = 0;
  localparam int ModeSlow = 1;
  localparam int ModeFast = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       jl = 1'b0, jr = 1'b0, ju = 1'b0, jd = 1'b0;
  logic       recenter = 1'b0;
  logic       analog_en = 1'b0;
  logic [7:0] ax = 8'h00, ay = 8'h00;
  logic [5:0] gun_h, gun_v;
  logic       moving;

  int n_pass  = 0;
  int n_total = 0;
  bit cmp_en  = 1'b0;

  // Model state, index 0 = horizontal, 1 = vertical.
  int m_pos[2];
  int m_mode[2];
  int m_dir[2];
  int m_div[2];
  int m_hold[2];
  bit m_tick_d;
  bit m_moving;

  gun_position_gen dut (
    .clock_12 (clk),
    .reset    (rst),
    .tick_4ms (tick),
    .joy_left (jl),
    .joy_right(jr),
    .joy_up   (ju),
    .joy_down (jd),
    .recenter (recenter),
    .analog_en(analog_en),
    .analog_x (ax),
    .analog_y (ay),
    .gun_h    (gun_h),
    .gun_v    (gun_v),
    .moving   (moving)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int clampi(input int v);
    if (v < 0) return 0;
    if (v > MaxV) return MaxV;
    return v;
  endfunction

  task automatic model_reset();
    for (int a = 0; a < 2; a++) begin
      m_pos[a] = Cen; m_mode[a] = ModeIdle; m_dir[a] = 0; m_div[a] = 0; m_hold[a] = 0;
    end
    m_tick_d = 1'b0;
    m_moving = 1'b0;
  endtask

  task automatic model_slow(input int a);
    if (m_div[a] == 0) m_pos[a] = clampi(m_pos[a] + m_dir[a]);
    m_div[a] = (m_div[a] + 1) % 4;
    m_hold[a]++;
    if (m_hold[a] == 16) m_mode[a] = ModeFast;
  endtask

  task automatic model_clock();
    bit step;
    int dir[2];
    int raw;
    bit entering;
    step = tick && !m_tick_d;
    m_tick_d = tick;
    dir[0] = (jr && !jl) ? 1 : ((jl && !jr) ? -1 : 0);
    dir[1] = (jd && !ju) ? 1 : ((ju && !jd) ? -1 : 0);
    for (int a = 0; a < 2; a++) begin
      if (recenter) begin
        m_pos[a] = Cen; m_mode[a] = ModeIdle; m_div[a] = 0; m_hold[a] = 0;
      end else if (analog_en) begin
        m_mode[a] = ModeIdle; m_div[a] = 0; m_hold[a] = 0;
        if (step) begin
          raw = (a == 0) ? int'($signed(ax)) : int'($signed(ay));
          m_pos[a] = clampi((raw + 128) / 4);
        end
      end else if (dir[a] == 0) begin
        m_mode[a] = ModeIdle; m_div[a] = 0; m_hold[a] = 0;
      end else if (m_mode[a] == ModeIdle || dir[a] != m_dir[a]) begin
        entering = (m_mode[a] == ModeIdle);
        m_mode[a] = ModeSlow; m_dir[a] = dir[a]; m_div[a] = 0; m_hold[a] = 0;
        if (entering && step) model_slow(a);
      end else if (step) begin
        if (m_mode[a] == ModeFast) m_pos[a] = clampi(m_pos[a] + 2 * dir[a]);
        else model_slow(a);
      end
    end
    m_moving = (m_mode[0] != ModeIdle) || (m_mode[1] != ModeIdle);
  endtask

  // Reference model advances on the same edges as the DUT.
  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else model_clock();
  end

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_gun_h", int'(gun_h), m_pos[0]);
      check("cyc_gun_v", int'(gun_v), m_pos[1]);
      check("cyc_moving", int'(moving), int'(m_moving));
    end
  end

  // n rising tick edges, two clocks apart; returns on a negedge after the last update.
  task automatic edges(input int n);
    repeat (n) begin
      @(negedge clk); tick = 1'b1;
      @(negedge clk); tick = 1'b0;
    end
  endtask

  task automatic pulse_recenter();
    @(negedge clk); recenter = 1'b1;
    @(negedge clk); recenter = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    cmp_en = 1'b1;
    check("reset_h", int'(gun_h), 32);
    check("reset_v", int'(gun_v), 32);
    check("reset_moving", int'(moving), 0);
    @(negedge clk); rst = 1'b0;

    // Slow phase then acceleration.
    @(negedge clk); jr = 1'b1;
    edges(1);  check("slow_e1", int'(gun_h), 33);
    edges(4);  check("slow_e5", int'(gun_h), 34);
    edges(4);  check("slow_e9", int'(gun_h), 35);
    edges(4);  check("slow_e13", int'(gun_h), 36);
    edges(3);  check("slow_e16", int'(gun_h), 36);
    check("model_fast", m_mode[0], ModeFast);
    check("moving_fast", int'(moving), 1);
    edges(7);  check("fast_50", int'(gun_h), 50);

    // Asynchronous reset in FAST, observed before any clock edge.
    @(posedge clk); #2 rst = 1'b1;
    #1;
    check("async_h", int'(gun_h), 32);
    check("async_v", int'(gun_v), 32);
    check("async_moving", int'(moving), 0);
    @(negedge clk); @(negedge clk); rst = 1'b0;

    edges(16); check("rerun_e16", int'(gun_h), 36);
    check("model_rerun", m_pos[0], 36);
    edges(10); check("fast_56", int'(gun_h), 56);
    edges(4);  check("clamp_63", int'(gun_h), 63);
    edges(3);  check("hold_63", int'(gun_h), 63);
    @(negedge clk); jr = 1'b0;

    // Opposing inputs cancel; releasing one resumes from the held value.
    pulse_recenter();
    check("recenter_h", int'(gun_h), 32);
    @(negedge clk); jr = 1'b1;
    edges(18); check("reach_40", int'(gun_h), 40);
    @(negedge clk); jl = 1'b1;
    edges(8);  check("opposed_40", int'(gun_h), 40);
    check("opposed_moving", int'(moving), 0);
    @(negedge clk); jr = 1'b0;
    edges(1);  check("left_39", int'(gun_h), 39);
    @(negedge clk); jl = 1'b0;

    // Analog tracking ignores the joystick.
    @(negedge clk);
    analog_en = 1'b1; ax = 8'h00; ay = 8'h80; jd = 1'b1; jr = 1'b1;
    edges(1);
    check("analog_h32", int'(gun_h), 32);
    check("analog_v0", int'(gun_v), 0);
    check("analog_moving", int'(moving), 0);
    check("model_analog_v", m_pos[1], 0);
    @(negedge clk); ax = 8'h7F;
    edges(1);  check("analog_h63", int'(gun_h), 63);
    @(negedge clk); analog_en = 1'b0; jd = 1'b0; jr = 1'b0;
    edges(2);  check("keep_h63", int'(gun_h), 63);
    @(negedge clk); jl = 1'b1;
    edges(1);  check("resume_62", int'(gun_h), 62);
    @(negedge clk); jl = 1'b0;

    // Recenter in FAST forces IDLE; slow rule restarts afterwards.
    pulse_recenter();
    @(negedge clk); ju = 1'b1;
    edges(25); check("up_fast_10", int'(gun_v), 10);
    pulse_recenter();
    check("recenter_v32", int'(gun_v), 32);
    check("recenter_idle", int'(moving), 0);
    edges(1);  check("after_recenter_31", int'(gun_v), 31);
    @(negedge clk); ju = 1'b0;

    // Randomized stimulus; changes land 1 time unit after the negedge.
    repeat (4000) begin
      @(negedge clk); #1;
      if ($urandom_range(0, 79) == 0) {jl, jr} = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 79) == 0) {ju, jd} = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) tick = ~tick;
      ax = 8'($urandom);
      ay = 8'($urandom);
      recenter = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 199) == 0) analog_en = ~analog_en;
      rst = ($urandom_range(0, 1499) == 0);
    end
    @(negedge clk); #1 rst = 1'b0;
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/gun_position_gen.md
Name: gun_position_gen

Overview:
- Produces the `gun_h`/`gun_v` crosshair position that the williams2 core reads through its gun ADC path.
- Digital mode: integrates joystick direction presses into a saturating position. Movement accelerates while a direction is held.
- Analog mode: tracks a stick position instead.
- Sits in the top level between the joystick decode and williams2. It is paced by the core's `cnt_4ms_o` tick, so crosshair speed is tied to game time.

Parameters:
- WIDTH, 6, bit width of each gun coordinate.
- MAX, 63, upper clamp value (≤ 2^WIDTH-1).
- CENTER, 32, reset/recenter value of both axes.
- SLOW_DIV, 4, tick edges per 1-step move in SLOW state.
- ACCEL_TICKS, 16, tick edges spent in SLOW before entering FAST.
- FAST_STEP, 2, step size per tick edge in FAST state.
- INVERT_V, 0, 0: up decrements `gun_v`; 1: up increments `gun_v`.

Ports:
- clock_12 in 1: system clock, 12 MHz.
- reset in 1: asynchronous, active-high reset.
- tick_4ms in 1: `cnt_4ms_o` from williams2, a level signal; its rising edge is the step event.
- joy_left in 1: left press, active-high, synchronous to clock_12.
- joy_right in 1: right press.
- joy_up in 1: up press.
- joy_down in 1: down press.
- recenter in 1: level; forces both axes to CENTER while high.
- analog_en in 1: 1 selects analog tracking mode.
- analog_x in 8: signed stick X, -128..127.
- analog_y in 8: signed stick Y.
- gun_h out WIDTH: horizontal gun position, registered.
- gun_v out WIDTH: vertical gun position, registered.
- moving out 1: 1 when either axis FSM is not IDLE.

Behaviour:
- Reset (async): `gun_h` = `gun_v` = CENTER; both FSMs IDLE; all counters 0; `tick_d` = 0; `moving` = 0.
- Step event: `step` = `tick_4ms & ~tick_d`, where `tick_d` is `tick_4ms` registered. Positions change only on cycles where `step` = 1; latency is 1 clock after the edge is seen.
- Per-axis direction:
  - H: +1 = right, -1 = left.
  - V: +1 = down, -1 = up; both signs are swapped when INVERT_V = 1.
  - Both opposing inputs high, or neither high, means no direction.
- Per-axis FSM (IDLE / SLOW / FAST); all transitions are evaluated every clock:
  - IDLE + direction present → SLOW; clear `div_cnt` and `hold_cnt`; latch the direction.
  - SLOW, on a step cycle: move 1 when `div_cnt` = 0; then `div_cnt` = (`div_cnt` + 1) mod SLOW_DIV; `hold_cnt`++.
  - SLOW: when `hold_cnt` reaches ACCEL_TICKS, enter FAST. The tick that reaches the count uses the slow rule.
  - FAST, on each step cycle: move FAST_STEP.
  - Direction released or opposing pair → IDLE, counters cleared, no move that cycle.
  - Direction reversed (latched ≠ current) → SLOW with counters cleared. The first step in the new direction happens on the next step cycle.
- Arithmetic: computed in WIDTH+2 signed bits and clamped to [0, MAX]. There is no wrap-around; holding at a limit keeps the value at the limit while the FSM state persists.
- Analog mode (`analog_en` = 1):
  - Both FSMs are forced IDLE.
  - On each step cycle: `gun_h` = min(MAX, (`analog_x` ^ 8'h80) >> (8 - WIDTH)). `gun_v` is computed the same way from `analog_y`; when INVERT_V = 0, `analog_y` is used as-is (stick up = negative = smaller `gun_v`).
  - Leaving analog mode keeps the current position and resumes digital integration from it.
- Recenter: while `recenter` = 1, both positions are set to CENTER every clock and both FSMs are held IDLE. It takes priority over analog mode and movement.
- Simultaneous events: a step cycle coinciding with an FSM entry uses the new state's rule. Example: IDLE → SLOW with `step` = 1 in the same cycle moves 1.
- `moving` = (H state ≠ IDLE) | (V state ≠ IDLE), registered.

Test Plan:
1. Reset asserted mid-FAST with `gun_h` = 50 → same cycle (async): `gun_h` = 32, `gun_v` = 32, `moving` = 0.
2. From 32, hold `joy_right`, 16 tick edges → `gun_h` = 33, 34, 35, 36 after edges 1, 5, 9, 13; 36 after edge 16; FSM = FAST.
3. Continue holding: after 10 more edges `gun_h` = 56; after 14 more edges `gun_h` = 63 (clamped); stays 63 on further edges.
4. Hold `joy_left` and `joy_right` together at `gun_h` = 40 for 8 edges → `gun_h` stays 40, `moving` = 0. Release right → `gun_h` = 39 at the next edge.
5. `analog_en` = 1, `analog_x` = 8'h00 (0), `analog_y` = 8'h80 (-128) → after one edge `gun_h` = 32, `gun_v` = 0. Set `analog_x` = 8'h7F → `gun_h` = 63. Joystick presses are ignored.
6. Hold `joy_up` in FAST at `gun_v` = 10, pulse `recenter` for 1 clock → `gun_v` = 32 and FSM IDLE. Next edge (up still held) → `gun_v` = 31.
